tthbif_uart_tx: RTL and testbench

// - UART transmitter (8N1, LSB first) driving the host-facing uart_tx_o pin of tthbif_top.
// - Counterpart of the UART receiver on uart_rx_i.
// - Serialises response/status bytes from the tthbif control logic back to the host.
// - Byte-wide valid/ready input; fixed-divisor bit timing derived from clk_i.

---
 rtl/tthbif_uart_tx_if.sv | 11 +
 rtl/tthbif_uart_tx.sv | 121 ++++++++++++
 tb/tb_tthbif_uart_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tthbif_uart_tx_if.sv
// Byte-wide valid/ready handshake between the tthbif control logic and the UART transmitter.
interface tthbif_uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tthbif_uart_tx.sv
// 8N1-style UART transmitter, LSB first, fixed divisor; drives the host-facing serial line.
// state | meaning
// IDLE  | line high, ready when enabled, waiting for a byte
// START | start bit (line low) for CLKS_PER_BIT cycles
// DATA  | DATA_BITS payload bits, LSB first, each CLKS_PER_BIT cycles
// STOP  | stop bit (line high) for CLKS_PER_BIT cycles
module tthbif_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  tthbif_uart_tx_if.slave  tx_if,
  output logic             busy_o,
  output logic             tx_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic accept;
  logic baud_last;
  logic bit_last;

  // rst_ni in the ready term keeps ready low for the whole reset window
  assign tx_if.tx_ready = rst_ni && en_i && (state_q == IDLE);
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  assign baud_last      = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign bit_last       = (bit_q == BIT_W'(DATA_BITS - 1));
  assign busy_o         = (state_q != IDLE);
  assign tx_o           = tx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = tx_if.tx_data;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_last) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // the line follows the bit that becomes shift[0] after this shift
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tthbif_uart_tx.sv
// Self-checking bench for tthbif_uart_tx: frame-level reference model plus literal line checks.
module tb_tthbif_uart_tx;

  localparam int CPB   = 4;
  localparam int DBITS = 8;
  localparam int FRAME = (DBITS + 2) * CPB;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  logic en_i   = 1'b0;
  logic busy_o;
  logic tx_o;

  tthbif_uart_tx_if #(.DATA_BITS(DBITS)) tx_if ();

  tthbif_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DBITS)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .tx_if  (tx_if.slave),
    .busy_o (busy_o),
    .tx_o   (tx_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // reference model: position inside the current frame (0 = idle, 1..FRAME = cycle of frame)
  int         m_pos     = 0;
  logic [9:0] m_bits    = 10'h3ff;
  int         m_acc_cnt = 0;
  int         m_acc_cyc = 0;

  logic line_hist [0:8191];
  logic busy_hist [0:8191];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge rst_ni) m_pos = 0;

  always @(posedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
      if (en_i && tx_if.tx_valid) begin
        m_bits    = {1'b1, tx_if.tx_data, 1'b0};
        m_pos     = 1;
        m_acc_cnt++;
        m_acc_cyc = cyc;
      end
    end else if (m_pos == FRAME) begin
      m_pos = 0;
    end else begin
      m_pos++;
    end
  end

  always @(negedge clk_i) begin
    if (cyc < 8192) begin
      line_hist[cyc] = tx_o;
      busy_hist[cyc] = busy_o;
    end
    if (chk_en) begin
      check("model_tx",    tx_o,           (m_pos == 0) ? 1'b1 : m_bits[(m_pos - 1) / CPB]);
      check("model_busy",  busy_o,         m_pos != 0);
      check("model_ready", tx_if.tx_ready, rst_ni && en_i && (m_pos == 0));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic wait_accept(input int budget, output int acc_cyc);
    int start = m_acc_cnt;
    int n = 0;
    while (m_acc_cnt == start && n < budget) begin
      step(1);
      n++;
    end
    if (m_acc_cnt == start) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: no accept within %0d cycles (cycle %0d)", budget, cyc);
    end
    acc_cyc = m_acc_cyc;
  endtask

  task automatic check_byte(input string name, input int c, input logic [7:0] b);
    int bad = 0;
    for (int i = 0; i < DBITS; i++)
      if (line_hist[c + CPB + i * CPB + 1] !== b[i]) bad++;
    check_int(name, bad, 0);
  endtask

  initial begin
    int c, c2, bad, zeros, acc0;
    logic [9:0] pat_a5;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;

    #1 rst_ni = 1'b0;
    en_i = 1'b1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hA5;
    #1 chk_en = 1'b1;
    step(4);
    check("rst_tx",    tx_o,           1'b1);
    check("rst_ready", tx_if.tx_ready, 1'b0);
    check("rst_busy",  busy_o,         1'b0);
    rst_ni = 1'b1;
    #1 check("post_rst_ready", tx_if.tx_ready, 1'b1);

    // single byte 0xA5
    wait_accept(5, c);
    tx_if.tx_valid = 1'b0;
    step(FRAME + 5);
    pat_a5 = 10'b1101001010;
    bad = 0;
    for (int i = 0; i < FRAME; i++)
      if (line_hist[c + i] !== pat_a5[i / CPB]) bad++;
    check_int("a5_line", bad, 0);
    zeros = 0;
    for (int i = 0; i < FRAME + 5; i++)
      if (busy_hist[c + i] === 1'b1) zeros++;
    check_int("a5_busy_cycles", zeros, FRAME);

    // back-to-back 0x00 then 0xFF, valid held
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h00;
    wait_accept(10, c);
    tx_if.tx_data  = 8'hFF;
    wait_accept(60, c2);
    tx_if.tx_valid = 1'b0;
    check_int("b2b_spacing", c2 - c, FRAME + 1);
    step(FRAME + 5);
    bad = 0;
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      logic e;
      e = (i < 36) ? 1'b0 : (i < 41) ? 1'b1 : (i < 45) ? 1'b0 : 1'b1;
      if (line_hist[c + i] !== e) bad++;
    end
    check_int("b2b_line", bad, 0);

    // data scrambled after accepting 0x3C
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h3C;
    wait_accept(10, c);
    tx_if.tx_valid = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      tx_if.tx_data = 8'($urandom);
      step(1);
    end
    check_byte("3c_payload", c - 1, 8'h3C);

    // en_i dropped mid-frame for 0x81, valid kept high with another byte
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h81;
    wait_accept(10, c);
    tx_if.tx_data  = 8'h5A;
    step(9);
    en_i = 1'b0;
    acc0 = m_acc_cnt;
    step(50);
    check_byte("en_drop_payload", c - 1, 8'h81);
    check("en_drop_ready", tx_if.tx_ready, 1'b0);
    check("en_drop_busy",  busy_o,         1'b0);
    check_int("en_drop_no_accept", m_acc_cnt, acc0);
    bad = 0;
    for (int i = FRAME; i < FRAME + 15; i++)
      if (line_hist[c + i] !== 1'b1) bad++;
    check_int("en_drop_line_idle", bad, 0);
    en_i = 1'b1;
    wait_accept(5, c);
    tx_if.tx_valid = 1'b0;
    step(FRAME + 3);
    check_byte("en_resume_payload", c - 1, 8'h5A);

    // reset pulse at cycle 17 of a frame
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h00;
    wait_accept(10, c);
    tx_if.tx_valid = 1'b0;
    step(16);
    check("pre_abort_tx", tx_o, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("abort_tx",    tx_o,   1'b1);
    check("abort_busy",  busy_o, 1'b0);
    step(1);
    rst_ni = 1'b1;
    #1;
    check("abort_ready", tx_if.tx_ready, 1'b1);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h55;
    wait_accept(5, c);
    tx_if.tx_valid = 1'b0;
    step(FRAME + 3);
    check_byte("post_abort_payload", c - 1, 8'h55);

    // randomized traffic with en_i toggling; the model checks every cycle
    for (int k = 0; k < 30; k++) begin
      step($urandom_range(0, 5));
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'($urandom);
      acc0 = m_acc_cnt;
      for (int n = 0; n < 400 && m_acc_cnt == acc0; n++) begin
        en_i = ($urandom_range(0, 3) != 0);
        step(1);
      end
      check_int("rand_accepted", m_acc_cnt, acc0 + 1);
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'($urandom);
      for (int n = 0; n < $urandom_range(0, FRAME + 4); n++) begin
        en_i = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    en_i = 1'b1;
    step(FRAME + 4);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
